// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the pulse train generator.
// Optional feature macro: SCALE_SHIFT_EN (length scaling by a captured left shift).
package pulse_gen_pkg;

   typedef enum logic [1:0] {PG_IDLE, PG_HIGH, PG_LOW} pg_state_t;

   localparam int SHIFT_W   = 3;
   localparam int MAX_SHIFT = 7;

endpackage

// File: rtl/pg_dur_counter.sv
// Duration counter: clr loads 1, inc advances by one, done when the count equals limit.
module pg_dur_counter #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   input  logic [CW-1:0] limit,
   output logic          done,
   output logic [CW-1:0] cnt_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = CW'(1);
      end else if (inc) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done  = (cnt_q == limit);
   assign cnt_o = cnt_q;

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable square-wave source: cfg_hi cycles high, cfg_lo cycles low, repeating while en.
// Optional feature macro: SCALE_SHIFT_EN adds cfg_shift; effective lengths become len << shift.
module pulse_train_gen
   import pulse_gen_pkg::*;
#(
   parameter int W = 8
) (
   input  logic               ref_clk,
   input  logic               rst,
   input  logic               en,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [W-1:0]       cfg_hi,
   input  logic [W-1:0]       cfg_lo,
`ifdef SCALE_SHIFT_EN
   input  logic [SHIFT_W-1:0] cfg_shift,
`endif
   output logic               wave_out,
   output logic               period_tick,
   output logic               running,
   output logic               err_zero,
   output pg_state_t          dbg_state
);

`ifdef SCALE_SHIFT_EN
   localparam int CNT_W = W + MAX_SHIFT;
`else
   localparam int CNT_W = W;
`endif

   // Handshake: a config transfers on any edge where cfg_valid && cfg_ready (ready = slot empty).
   pg_state_t      state_q;
   logic           wave_q, tick_q, running_q, err_q;
   logic           pending_q, active_ok_q;
   logic [W-1:0]   pend_hi_q, pend_lo_q, act_hi_q, act_lo_q;
`ifdef SCALE_SHIFT_EN
   logic [SHIFT_W-1:0] pend_shift_q, act_shift_q;
`endif

   logic [CNT_W-1:0] eff_hi, eff_lo, limit, cnt;
   logic [CNT_W:0]   cnt_p1;
   logic             done, cnt_clr, cnt_inc;
   logic             hs, hs_zero, hs_ok, start_idle, restart, period_start;

   always_comb begin
`ifdef SCALE_SHIFT_EN
      eff_hi = CNT_W'(act_hi_q) << act_shift_q;
      eff_lo = CNT_W'(act_lo_q) << act_shift_q;
`else
      eff_hi = CNT_W'(act_hi_q);
      eff_lo = CNT_W'(act_lo_q);
`endif
      hs           = cfg_valid && !pending_q;
      hs_zero      = hs && ((cfg_hi == '0) || (cfg_lo == '0));
      hs_ok        = hs && !hs_zero;
      start_idle   = (state_q == PG_IDLE) && en && (active_ok_q || pending_q);
      restart      = (state_q == PG_LOW) && done && en;
      period_start = start_idle || restart;
      limit        = (state_q == PG_HIGH) ? eff_hi : eff_lo;
      cnt_clr      = period_start || ((state_q == PG_HIGH) && done);
      cnt_inc      = (state_q != PG_IDLE) && !done;
      cnt_p1       = {1'b0, cnt} + (CNT_W+1)'(1);
   end

   pg_dur_counter #(.CW(CNT_W)) u_cnt (
      .clk   (ref_clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .limit (limit),
      .done  (done),
      .cnt_o (cnt)
   );

   always_ff @(posedge ref_clk) begin
      if (rst) begin
         state_q     <= PG_IDLE;
         wave_q      <= 1'b0;
         tick_q      <= 1'b0;
         running_q   <= 1'b0;
         err_q       <= 1'b0;
         pending_q   <= 1'b0;
         active_ok_q <= 1'b0;
         pend_hi_q   <= '0;
         pend_lo_q   <= '0;
         act_hi_q    <= '0;
         act_lo_q    <= '0;
`ifdef SCALE_SHIFT_EN
         pend_shift_q <= '0;
         act_shift_q  <= '0;
`endif
      end else begin
         err_q <= hs_zero;
         // Consume and capture are exclusive: a capture needs an empty slot, a consume a full one.
         if (period_start && pending_q) begin
            act_hi_q    <= pend_hi_q;
            act_lo_q    <= pend_lo_q;
`ifdef SCALE_SHIFT_EN
            act_shift_q <= pend_shift_q;
`endif
            active_ok_q <= 1'b1;
            pending_q   <= 1'b0;
         end else if (hs_ok) begin
            pend_hi_q    <= cfg_hi;
            pend_lo_q    <= cfg_lo;
`ifdef SCALE_SHIFT_EN
            pend_shift_q <= cfg_shift;
`endif
            pending_q    <= 1'b1;
         end

         // tick_q is predicted one edge early so it lands in the last LOW cycle.
         case (state_q)
            PG_IDLE: begin
               tick_q <= 1'b0;
               if (start_idle) begin
                  state_q   <= PG_HIGH;
                  wave_q    <= 1'b1;
                  running_q <= 1'b1;
               end
            end
            PG_HIGH: begin
               if (done) begin
                  state_q <= PG_LOW;
                  wave_q  <= 1'b0;
                  tick_q  <= (eff_lo == CNT_W'(1));
               end else begin
                  tick_q  <= 1'b0;
               end
            end
            PG_LOW: begin
               if (done) begin
                  tick_q    <= 1'b0;
                  state_q   <= en ? PG_HIGH : PG_IDLE;
                  wave_q    <= en;
                  running_q <= en;
               end else begin
                  tick_q    <= (cnt_p1 == {1'b0, eff_lo});
               end
            end
            default: begin
               state_q   <= PG_IDLE;
               wave_q    <= 1'b0;
               tick_q    <= 1'b0;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_ready   = !pending_q;
   assign wave_out    = wave_q;
   assign period_tick = tick_q;
   assign running     = running_q;
   assign err_zero    = err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: drivers queue per-cycle expectations, a negedge monitor checks them.
module tb_pulse_train_gen;

   logic       ref_clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       cfg_valid = 1'b0;
   logic [7:0] cfg_hi = '0;
   logic [7:0] cfg_lo = '0;
`ifdef SCALE_SHIFT_EN
   logic [2:0] cfg_shift = '0;
`endif
   logic       cfg_ready, wave_out, period_tick, running, err_zero;
   logic [1:0] dbg_state;

   // Expected vector bits: {wave_out, period_tick, running, cfg_ready, err_zero}
   logic [4:0] exp_q[$];
   int         errors = 0;
   int         checks = 0;
   int         cyc_n  = 0;
   string      tname  = "reset";

   always #5 ref_clk = ~ref_clk;

   pulse_train_gen #(.W(8)) dut (
      .ref_clk     (ref_clk),
      .rst         (rst),
      .en          (en),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_hi      (cfg_hi),
      .cfg_lo      (cfg_lo),
`ifdef SCALE_SHIFT_EN
      .cfg_shift   (cfg_shift),
`endif
      .wave_out    (wave_out),
      .period_tick (period_tick),
      .running     (running),
      .err_zero    (err_zero),
      .dbg_state   (dbg_state)
   );

   // Monitor: one popped expectation per cycle, compared mid-cycle.
   initial begin
      logic [4:0] got, e;
      forever begin
         @(negedge ref_clk);
         if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            got = {wave_out, period_tick, running, cfg_ready, err_zero};
            checks++;
            if (got !== e) begin
               errors++;
               $display("FAIL %s cyc=%0d wave/tick/run/rdy/err got=%b exp=%b", tname, cyc_n, got, e);
            end
            cyc_n++;
         end
      end
   end

   task automatic cyc(input logic e, input logic v, input logic [7:0] h, input logic [7:0] l,
                      input logic [4:0] exp);
      en        = e;
      cfg_valid = v;
      cfg_hi    = h;
      cfg_lo    = l;
      @(posedge ref_clk);
      #1;
      cfg_valid = 1'b0;
      exp_q.push_back(exp);
   endtask

   task automatic rcyc(input logic e);
      rst       = 1'b1;
      en        = e;
      cfg_valid = 1'b0;
      @(posedge ref_clk);
      #1;
      rst = 1'b0;
      exp_q.push_back(5'b00010);
   endtask

   // One full period; en is driven low from cycle index en_from onwards.
   task automatic period(input int hi, input int lo, input int en_from);
      for (int i = 0; i < hi + lo; i++) begin
         logic [4:0] e;
         if (i < hi)               e = 5'b10110;
         else if (i < hi + lo - 1) e = 5'b00110;
         else                      e = 5'b01110;
         cyc((i < en_from) ? 1'b1 : 1'b0, 1'b0, 8'd0, 8'd0, e);
      end
   endtask

   initial begin
      rcyc(1'b0);
      rcyc(1'b0);

      tname = "basic_3_2";
      cyc(1'b1, 1'b1, 8'd3, 8'd2, 5'b00000);
      for (int p = 0; p < 3; p++) period(3, 2, 5);

      tname = "reconfig_mid_high";
      cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b10110);
      cyc(1'b1, 1'b1, 8'd1, 8'd1, 5'b10100);
      cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b10100);
      cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b00100);
      cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b01100);
      period(1, 1, 2);
      period(1, 1, 2);

      tname = "zero_hi";
      cyc(1'b1, 1'b1, 8'd0, 8'd5, 5'b10111);
      cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b01110);
      period(1, 1, 2);

      tname = "cfg_in_last_low";
      cyc(1'b1, 1'b1, 8'd4, 8'd4, 5'b10100);
      cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b01100);
      tname = "en_drop_4_4";
      period(4, 4, 2);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'd0, 8'd0, 5'b00010);

      tname = "rst_in_low";
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b10110);
      cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b00110);
      cyc(1'b1, 1'b1, 8'd2, 8'd2, 5'b00100);
      rcyc(1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b00010);

      tname = "zero_lo_idle";
      cyc(1'b0, 1'b1, 8'd5, 8'd0, 5'b00011);
      cyc(1'b1, 1'b0, 8'd0, 8'd0, 5'b00010);

      tname = "max_255_255";
      cyc(1'b1, 1'b1, 8'd255, 8'd255, 5'b00000);
      period(255, 255, 1);
      cyc(1'b0, 1'b0, 8'd0, 8'd0, 5'b00010);

`ifdef SCALE_SHIFT_EN
      tname = "shift_3_1_s2";
      cfg_shift = 3'd2;
      cyc(1'b1, 1'b1, 8'd3, 8'd1, 5'b00000);
      cfg_shift = 3'd0;
      period(12, 4, 1);
      cyc(1'b0, 1'b0, 8'd0, 8'd0, 5'b00010);
`endif

      tname = "drain";
      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge ref_clk);
      @(posedge ref_clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
